// File: rtl/fsm_snoop_rsp_ctrl_pkg.sv
// Shared cache definitions for the snoop-response controller slice.
// Provides the MESI line-state encoding, the bus request/response encodings,
// the snoop FSM state type and the decoded-action record that the decision
// logic hands back to the controller.
package fsm_snoop_rsp_ctrl_pkg;

    typedef enum logic [2:0] {
        INVALID   = 3'd0,
        SHARED    = 3'd1,
        EXCLUSIVE = 3'd2,
        MODIFIED  = 3'd3
    } mesi_e;

    typedef enum logic [1:0] {
        BUS_NO_REQ         = 2'd0,
        BUS_READ_REQ       = 2'd1,
        BUS_RWITM_REQ      = 2'd2,
        BUS_INVALIDATE_REQ = 2'd3
    } bus_req_e;

    typedef enum logic [1:0] {
        BUS_NO_RSP          = 2'd0,
        BUS_SNOOP_FOUND_RSP = 2'd1
    } bus_rsp_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        WAIT_LK = 3'd2,
        FLUSH   = 3'd3,
        UPDATE  = 3'd4,
        RESP    = 3'd5
    } snoop_fsm_e;

    // Action chosen for one snooped request against the looked-up line.
    typedef struct packed {
        logic     flush;      // write the dirty line back first
        logic     upd;        // state array must be rewritten
        mesi_e    new_state;  // value for that rewrite
        bus_rsp_e rsp;        // response returned to the arbiter
        logic     proto_err;  // invalidate seen against an owned line
    } snoop_act_t;

endpackage

// File: rtl/fsm_snoop_rsp_ctrl_if.sv
// Shared-bus side of the snoop responder: the snooped request handshake and
// the snoop response handshake.
//   bus_req_vld/bus_req/bus_req_addr/bus_req_rdy : incoming snooped request
//   snoop_rsp_vld/snoop_rsp/snoop_rsp_rdy         : response to the arbiter
// master = bus/arbiter side, slave = snoop controller.
interface fsm_snoop_rsp_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req_vld;
    logic [1:0]        bus_req;
    logic [ADDR_W-1:0] bus_req_addr;
    logic              bus_req_rdy;
    logic              snoop_rsp_vld;
    logic [1:0]        snoop_rsp;
    logic              snoop_rsp_rdy;

    modport master (
        output bus_req_vld, bus_req, bus_req_addr, snoop_rsp_rdy,
        input  bus_req_rdy, snoop_rsp_vld, snoop_rsp
    );

    modport slave (
        input  bus_req_vld, bus_req, bus_req_addr, snoop_rsp_rdy,
        output bus_req_rdy, snoop_rsp_vld, snoop_rsp
    );
endinterface

// File: rtl/fsm_snoop_rsp_ctrl_snoop_mesi_decode.sv
// snoop_mesi_decode: purely combinational MESI decision table.
//   req        : captured bus request
//   hit        : tag match from the lookup (a miss is handled as INVALID)
//   line_state : MESI state of the hit line, ignored on a miss
//   act        : flush / update / new state / response / protocol-error flags
module snoop_mesi_decode
    import fsm_snoop_rsp_ctrl_pkg::*;
(
    input  bus_req_e   req,
    input  logic       hit,
    input  mesi_e      line_state,
    output snoop_act_t act
);

    mesi_e eff_state;

    always_comb begin
        eff_state     = hit ? line_state : INVALID;
        act.flush     = 1'b0;
        act.upd       = 1'b0;
        act.new_state = INVALID;
        act.rsp       = BUS_NO_RSP;
        act.proto_err = 1'b0;

        case (req)
            BUS_READ_REQ: begin
                case (eff_state)
                    MODIFIED: begin
                        act.flush     = 1'b1;
                        act.upd       = 1'b1;
                        act.new_state = SHARED;
                        act.rsp       = BUS_SNOOP_FOUND_RSP;
                    end
                    EXCLUSIVE, SHARED: begin
                        act.upd       = 1'b1;
                        act.new_state = SHARED;
                        act.rsp       = BUS_SNOOP_FOUND_RSP;
                    end
                    default: ;
                endcase
            end
            BUS_RWITM_REQ: begin
                case (eff_state)
                    MODIFIED: begin
                        act.flush     = 1'b1;
                        act.upd       = 1'b1;
                        act.new_state = INVALID;
                        act.rsp       = BUS_SNOOP_FOUND_RSP;
                    end
                    EXCLUSIVE, SHARED: begin
                        act.upd       = 1'b1;
                        act.new_state = INVALID;
                        act.rsp       = BUS_SNOOP_FOUND_RSP;
                    end
                    default: ;
                endcase
            end
            BUS_INVALIDATE_REQ: begin
                case (eff_state)
                    SHARED: begin
                        act.upd       = 1'b1;
                        act.new_state = INVALID;
                        act.rsp       = BUS_SNOOP_FOUND_RSP;
                    end
                    // An invalidate implies the requester holds a shared copy,
                    // so an owned line here is a coherence violation; the line
                    // is still dropped so the system converges.
                    MODIFIED, EXCLUSIVE: begin
                        act.upd       = 1'b1;
                        act.new_state = INVALID;
                        act.rsp       = BUS_SNOOP_FOUND_RSP;
                        act.proto_err = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fsm_snoop_rsp_ctrl.sv
// fsm_snoop_rsp_ctrl: snoop-side MESI responder. Accepts one snooped bus
// request at a time, looks up the local line, flushes a MODIFIED line when
// the request needs the data, rewrites the line state and answers the arbiter.
//   clk, rst_n               : clock, asynchronous active-low reset
//   bus (slave)              : snooped request in, snoop response out
//   lkup_vld/lkup_addr       : tag lookup strobe and held lookup address
//   lkup_hit/lkup_state      : lookup result, valid LKUP_LAT cycles later
//   flush_vld/flush_rdy      : dirty-line write-back handshake
//   upd_vld/upd_state        : one-cycle state-array write at lkup_addr
//   err_proto/err_flush_tmo  : sticky error flags
// All outputs come straight from flops.
module fsm_snoop_rsp_ctrl
    import fsm_snoop_rsp_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LKUP_LAT  = 1,
    parameter int FLUSH_TMO = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    fsm_snoop_rsp_ctrl_if.slave bus,
    output logic              lkup_vld,
    output logic [ADDR_W-1:0] lkup_addr,
    input  logic              lkup_hit,
    input  logic [2:0]        lkup_state,
    output logic              flush_vld,
    input  logic              flush_rdy,
    output logic              upd_vld,
    output logic [2:0]        upd_state,
    output logic              err_proto,
    output logic              err_flush_tmo
);

    localparam logic [2:0] LAT_LOAD  = 3'(LKUP_LAT);
    localparam logic [7:0] TMO_LIMIT = 8'(FLUSH_TMO);

    snoop_fsm_e        state_q, state_d;
    bus_req_e          req_q, req_d;
    logic [ADDR_W-1:0] addr_d;
    logic [2:0]        lat_q, lat_d;
    logic [7:0]        tmo_q, tmo_d;
    mesi_e             new_state_q, new_state_d;
    bus_rsp_e          rsp_code_q, rsp_code_d;
    logic              err_proto_d, err_tmo_d;

    logic              rdy_d, lkup_vld_d, flush_vld_d, upd_vld_d, rsp_vld_d;
    mesi_e             upd_state_d;
    bus_rsp_e          rsp_d;

    snoop_act_t        act;

    snoop_mesi_decode u_decode (
        .req        (req_q),
        .hit        (lkup_hit),
        .line_state (mesi_e'(lkup_state)),
        .act        (act)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = lkup_addr;
        lat_d       = lat_q;
        tmo_d       = tmo_q;
        new_state_d = new_state_q;
        rsp_code_d  = rsp_code_q;
        err_proto_d = err_proto;
        err_tmo_d   = err_flush_tmo;

        case (state_q)
            IDLE: begin
                // A valid BUS_NO_REQ is consumed here and simply dropped.
                if (bus.bus_req_vld && (bus_req_e'(bus.bus_req) != BUS_NO_REQ)) begin
                    req_d   = bus_req_e'(bus.bus_req);
                    addr_d  = bus.bus_req_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                lat_d   = LAT_LOAD;
                state_d = WAIT_LK;
            end
            WAIT_LK: begin
                lat_d = lat_q - 3'd1;
                if (lat_d == '0) begin
                    new_state_d = act.new_state;
                    rsp_code_d  = act.rsp;
                    err_proto_d = err_proto | act.proto_err;
                    tmo_d       = '0;
                    if (act.flush)
                        state_d = FLUSH;
                    else if (act.upd)
                        state_d = UPDATE;
                    else
                        state_d = RESP;
                end
            end
            FLUSH: begin
                if (flush_rdy) begin
                    state_d = UPDATE;
                end else if (tmo_q != TMO_LIMIT) begin
                    // Counter saturates at the limit; the flag only reports,
                    // the write-back is never abandoned.
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_d == TMO_LIMIT)
                        err_tmo_d = 1'b1;
                end
            end
            UPDATE: begin
                state_d = RESP;
            end
            RESP: begin
                if (bus.snoop_rsp_rdy)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so that they can be
        // registered without adding a cycle of latency.
        rdy_d       = (state_d == IDLE);
        lkup_vld_d  = (state_d == LOOKUP);
        flush_vld_d = (state_d == FLUSH);
        upd_vld_d   = (state_d == UPDATE);
        upd_state_d = (state_d == UPDATE) ? new_state_d : INVALID;
        rsp_vld_d   = (state_d == RESP);
        rsp_d       = (state_d == RESP) ? rsp_code_d : BUS_NO_RSP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            req_q             <= BUS_NO_REQ;
            lkup_addr         <= '0;
            lat_q             <= '0;
            tmo_q             <= '0;
            new_state_q       <= INVALID;
            rsp_code_q        <= BUS_NO_RSP;
            err_proto         <= 1'b0;
            err_flush_tmo     <= 1'b0;
            bus.bus_req_rdy   <= 1'b1;
            lkup_vld          <= 1'b0;
            flush_vld         <= 1'b0;
            upd_vld           <= 1'b0;
            upd_state         <= '0;
            bus.snoop_rsp_vld <= 1'b0;
            bus.snoop_rsp     <= '0;
        end else begin
            state_q           <= state_d;
            req_q             <= req_d;
            lkup_addr         <= addr_d;
            lat_q             <= lat_d;
            tmo_q             <= tmo_d;
            new_state_q       <= new_state_d;
            rsp_code_q        <= rsp_code_d;
            err_proto         <= err_proto_d;
            err_flush_tmo     <= err_tmo_d;
            bus.bus_req_rdy   <= rdy_d;
            lkup_vld          <= lkup_vld_d;
            flush_vld         <= flush_vld_d;
            upd_vld           <= upd_vld_d;
            upd_state         <= upd_state_d;
            bus.snoop_rsp_vld <= rsp_vld_d;
            bus.snoop_rsp     <= rsp_d;
        end
    end

endmodule

// File: tb/tb_fsm_snoop_rsp_ctrl.sv
module tb_fsm_snoop_rsp_ctrl;
    import fsm_snoop_rsp_ctrl_pkg::*;

    localparam int ADDR_W = 32;
    localparam int LAT    = 1;
    localparam int TMO    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fsm_snoop_rsp_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    logic              lkup_vld;
    logic [ADDR_W-1:0] lkup_addr;
    logic              lkup_hit;
    logic [2:0]        lkup_state;
    logic              flush_vld;
    logic              flush_rdy;
    logic              upd_vld;
    logic [2:0]        upd_state;
    logic              err_proto;
    logic              err_flush_tmo;

    fsm_snoop_rsp_ctrl #(
        .ADDR_W    (ADDR_W),
        .LKUP_LAT  (LAT),
        .FLUSH_TMO (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .lkup_vld      (lkup_vld),
        .lkup_addr     (lkup_addr),
        .lkup_hit      (lkup_hit),
        .lkup_state    (lkup_state),
        .flush_vld     (flush_vld),
        .flush_rdy     (flush_rdy),
        .upd_vld       (upd_vld),
        .upd_state     (upd_state),
        .err_proto     (err_proto),
        .err_flush_tmo (err_flush_tmo)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    logic exp_proto = 1'b0;
    logic exp_tmo   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".rdy"},       32'(bus.bus_req_rdy),   1);
        chk({tag, ".lkup_vld"},  32'(lkup_vld),          0);
        chk({tag, ".flush_vld"}, 32'(flush_vld),         0);
        chk({tag, ".upd_vld"},   32'(upd_vld),           0);
        chk({tag, ".rsp_vld"},   32'(bus.snoop_rsp_vld), 0);
        chk({tag, ".err_proto"}, 32'(err_proto),         32'(exp_proto));
        chk({tag, ".err_tmo"},   32'(err_flush_tmo),     32'(exp_tmo));
    endtask

    task automatic reset_dut(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, ".rst_rdy"},       32'(bus.bus_req_rdy),   1);
        chk({tag, ".rst_lkup_vld"},  32'(lkup_vld),          0);
        chk({tag, ".rst_lkup_addr"}, lkup_addr,              0);
        chk({tag, ".rst_flush_vld"}, 32'(flush_vld),         0);
        chk({tag, ".rst_upd_vld"},   32'(upd_vld),           0);
        chk({tag, ".rst_upd_state"}, 32'(upd_state),         0);
        chk({tag, ".rst_rsp_vld"},   32'(bus.snoop_rsp_vld), 0);
        chk({tag, ".rst_rsp"},       32'(bus.snoop_rsp),     0);
        chk({tag, ".rst_err_proto"}, 32'(err_proto),         0);
        chk({tag, ".rst_err_tmo"},   32'(err_flush_tmo),     0);
        exp_proto         = 1'b0;
        exp_tmo           = 1'b0;
        bus.bus_req_vld   = 1'b0;
        bus.bus_req       = BUS_NO_REQ;
        bus.bus_req_addr  = '0;
        bus.snoop_rsp_rdy = 1'b0;
        lkup_hit          = 1'b0;
        lkup_state        = '0;
        flush_rdy         = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One idle cycle: either nothing valid, or a valid BUS_NO_REQ to be dropped.
    task automatic idle_step(input bit send_noreq);
        @(negedge clk);
        check_idle("idle");
        bus.bus_req_vld  = send_noreq;
        bus.bus_req      = send_noreq ? BUS_NO_REQ : 2'($urandom_range(1, 3));
        bus.bus_req_addr = $urandom;
    endtask

    // One snooped transaction. Cycle 0 is the accept cycle; the expected
    // timeline is derived from the lookup latency, the flush stall count fd
    // and the response back-pressure count rd. abort_k > 0 stops after
    // checking that cycle.
    task automatic do_txn(input string tag, input bus_req_e req, input logic [31:0] addr,
                          input logic hit, input mesi_e st, input int fd, input int rd,
                          input int abort_k);
        mesi_e eff;
        bit    found, fl, pe, tmo_hit;
        mesi_e ns;
        int    t_fl0, t_upd, t_rsp, t_end;
        eff     = hit ? st : INVALID;
        found   = (eff != INVALID);
        fl      = found && (eff == MODIFIED) && (req != BUS_INVALIDATE_REQ);
        pe      = found && (req == BUS_INVALIDATE_REQ) && (eff == MODIFIED || eff == EXCLUSIVE);
        ns      = (req == BUS_READ_REQ) ? SHARED : INVALID;
        tmo_hit = fl && (fd >= TMO);
        t_fl0   = LAT + 2;
        t_upd   = fl ? LAT + 3 + fd : LAT + 2;
        t_rsp   = found ? t_upd + 1 : LAT + 2;
        t_end   = t_rsp + rd;

        @(negedge clk);
        check_idle({tag, ".c0"});
        bus.bus_req_vld   = 1'b1;
        bus.bus_req       = req;
        bus.bus_req_addr  = addr;
        lkup_hit          = 1'b0;
        lkup_state        = 3'($urandom_range(0, 7));
        flush_rdy         = 1'($urandom);
        bus.snoop_rsp_rdy = 1'($urandom);

        for (int k = 1; k <= t_end; k++) begin
            @(negedge clk);
            if (pe && k == LAT + 2) exp_proto = 1'b1;
            if (tmo_hit && k == LAT + 2 + TMO) exp_tmo = 1'b1;
            chk({tag, ".rdy"},       32'(bus.bus_req_rdy), 0);
            chk({tag, ".lkup_vld"},  32'(lkup_vld), 32'(k == 1));
            chk({tag, ".lkup_addr"}, lkup_addr, addr);
            chk({tag, ".flush_vld"}, 32'(flush_vld), 32'(fl && k >= t_fl0 && k <= t_fl0 + fd));
            chk({tag, ".upd_vld"},   32'(upd_vld), 32'(found && k == t_upd));
            if (found && k == t_upd)
                chk({tag, ".upd_state"}, 32'(upd_state), 32'(ns));
            chk({tag, ".rsp_vld"},   32'(bus.snoop_rsp_vld), 32'(k >= t_rsp));
            if (k >= t_rsp)
                chk({tag, ".rsp"}, 32'(bus.snoop_rsp),
                    found ? 32'(BUS_SNOOP_FOUND_RSP) : 32'(BUS_NO_RSP));
            chk({tag, ".err_proto"}, 32'(err_proto), 32'(exp_proto));
            chk({tag, ".err_tmo"},   32'(err_flush_tmo), 32'(exp_tmo));
            if (k == abort_k) return;

            // Busy-time request traffic must be ignored.
            bus.bus_req_vld   = 1'($urandom);
            bus.bus_req       = 2'($urandom_range(0, 3));
            bus.bus_req_addr  = $urandom;
            lkup_hit          = (k == LAT + 1) ? hit : 1'b0;
            lkup_state        = (k == LAT + 1) ? 3'(st) : 3'($urandom_range(0, 7));
            flush_rdy         = (fl && k >= t_fl0) ? (k == t_fl0 + fd) : 1'($urandom);
            bus.snoop_rsp_rdy = (k >= t_rsp) ? (k == t_end) : 1'($urandom);
        end
    endtask

    task automatic random_phase(input int n, input int max_fd);
        bus_req_e rq;
        mesi_e    s;
        logic     h;
        for (int i = 0; i < n; i++) begin
            rq = bus_req_e'(2'($urandom_range(1, 3)));
            s  = mesi_e'(3'($urandom_range(0, 3)));
            h  = 1'($urandom);
            do_txn("rand", rq, $urandom, h, s, $urandom_range(0, max_fd), $urandom_range(0, 3), 0);
            if ($urandom_range(0, 3) == 0) idle_step(1'($urandom));
        end
    endtask

    initial begin
        bus.bus_req_vld   = 1'b0;
        bus.bus_req       = BUS_NO_REQ;
        bus.bus_req_addr  = '0;
        bus.snoop_rsp_rdy = 1'b0;
        lkup_hit          = 1'b0;
        lkup_state        = '0;
        flush_rdy         = 1'b0;

        reset_dut("por");

        do_txn("s1_read_e",  BUS_READ_REQ,  32'h40,   1'b1, EXCLUSIVE, 0, 0, 0);
        do_txn("s2_rwitm_m", BUS_RWITM_REQ, 32'h80,   1'b1, MODIFIED,  2, 1, 0);
        do_txn("s3_miss",    BUS_READ_REQ,  32'h1234, 1'b0, mesi_e'(3'($urandom_range(0, 3))), 0, 2, 0);
        idle_step(1'b1);
        idle_step(1'b0);
        idle_step(1'b1);
        do_txn("read_m",     BUS_READ_REQ,  32'hA0,   1'b1, MODIFIED,  0, 0, 0);
        do_txn("inval_s",    BUS_INVALIDATE_REQ, 32'hB0, 1'b1, SHARED, 0, 1, 0);

        random_phase(40, TMO - 1);

        reset_dut("mid");
        do_txn("s4_inval_e", BUS_INVALIDATE_REQ, 32'hC0, 1'b1, EXCLUSIVE, 0, 0, 0);
        do_txn("s4_sticky",  BUS_READ_REQ,  32'hC4,   1'b1, SHARED,    0, 0, 0);
        do_txn("s5_tmo",     BUS_RWITM_REQ, 32'h100,  1'b1, MODIFIED, 10, 0, 0);
        idle_step(1'b0);

        do_txn("s6_abort",   BUS_RWITM_REQ, 32'h140,  1'b1, MODIFIED, 20, 0, LAT + 4);
        bus.snoop_rsp_rdy = 1'b0;
        flush_rdy         = 1'b0;
        reset_dut("s6_rst");
        do_txn("s6_after",   BUS_READ_REQ,  32'h40,   1'b1, EXCLUSIVE, 0, 0, 0);

        random_phase(30, TMO + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
